debug_unit: RTL and testbench
=============================

Name: debug_unit

Overview:
- Sits inside TOP_MIPS, between the UART and the MIPS pipeline.
- Receives the program as UART bytes, assembles them into 32-bit words and writes them into instruction memory.
- Waits for a command byte, then runs the CPU until it halts.
- Streams PC, the 32 registers and 32 data-memory words back over the UART, 4 bytes each, LSB first.

Parameters:
- DATA_WIDTH, 32, CPU word width.
- DATA_WIDTH_UART, 8, UART byte width.
- IMEM_ADDR_WIDTH, 8, instruction memory word-address width (256 words).
- NREGS, 32, registers dumped.
- NMEMWORDS, 32, data-memory words dumped (addresses 0..NMEMWORDS-1).
- HALT_OPCODE, 6'b111111, opcode field [31:26] marking a halt instruction.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset. Asynchronous, active-high.
- i_rx_done  in  1  one-cycle pulse: i_rx_data is a valid received byte.
- i_rx_data  in  8  received UART byte.
- i_tx_done  in  1  one-cycle pulse: the UART has finished sending the last byte.
- o_tx_signal  out  1  one-cycle pulse: start sending o_tx_result.
- o_tx_result  out  8  byte to send; held stable until i_tx_done.
- o_imem_wr_en  out  1  instruction memory write strobe.
- o_imem_addr  out  IMEM_ADDR_WIDTH  instruction memory word address.
- o_imem_data  out  DATA_WIDTH  instruction word to write.
- o_cpu_enable  out  1  pipeline clock-enable.
- i_halt  in  1  CPU has retired a halt; level signal.
- i_pc  in  DATA_WIDTH  current PC.
- o_reg_addr  out  5  register-file debug read address.
- i_reg_data  in  DATA_WIDTH  register read data, valid 1 cycle after o_reg_addr.
- o_mem_addr  out  DATA_WIDTH  data-memory debug read word address.
- i_mem_data  in  DATA_WIDTH  memory read data, valid 1 cycle after o_mem_addr.
- o_state  out  3  current FSM state, for debug.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in LOAD; byte counter 0, imem address 0, halt_seen 0.
  - Reset at any point (mid-load, run or dump) aborts to this state; any partial word is discarded.
- LOAD:
  - Each i_rx_done shifts i_rx_data into byte[bytecnt], LSB first; bytecnt increments 0..3.
  - On the 4th byte: go to LOAD_WR.
- LOAD_WR, one cycle:
  - o_imem_wr_en=1, o_imem_addr=word address, o_imem_data=assembled word; then the address increments.
  - If the word's opcode is HALT_OPCODE, set halt_seen.
  - If halt_seen was already set and the word is 32'h0 (end marker), go to WAIT_CMD.
  - Otherwise return to LOAD.
  - If the address wraps to 0 after the write of word 2^IMEM_ADDR_WIDTH-1, go to WAIT_CMD (memory full).
- WAIT_CMD:
  - Byte 8'h00 moves to RUN.
  - Any other byte is ignored (except the step command under the optional feature below).
- RUN:
  - o_cpu_enable=1 from the cycle after the command byte.
  - When i_halt is sampled high, o_cpu_enable drops the next cycle and the FSM goes to DUMP.
  - rx bytes are ignored during RUN.
- DUMP sequence: item 0 = i_pc, items 1..NREGS = registers 0..31, then NMEMWORDS memory words.
  - For each item: SETUP presents the address, then one wait cycle, then the word is latched into a 32-bit shift register.
  - Four bytes are then sent. SEND: o_tx_signal=1 for 1 cycle with o_tx_result=byte. WAITTX holds until i_tx_done.
  - No new o_tx_signal is issued before i_tx_done for the previous byte.
  - Total 4*(1+NREGS+NMEMWORDS)=260 bytes at defaults.
- After the last i_tx_done: clear imem address and halt_seen, then return to LOAD.
- Simultaneous events:
  - An i_rx_done in the same cycle as the LOAD_WR write is not possible; the UART minimum byte spacing exceeds 1 cycle.
  - i_halt already high on entry to RUN: enable pulses for one cycle, then the dump starts.

Optional Feature:
- Macro: DEBUG_STEP_EN.
- With the macro defined:
  - Command 8'h01 in WAIT_CMD enters STEP.
  - Each rx byte 8'h02 gives o_cpu_enable=1 for exactly one cycle, followed by a full 260-byte dump; the FSM then returns to STEP.
  - If i_halt is high when the dump finishes, go to LOAD.
  - Other bytes in STEP are ignored.
- Without the macro: 8'h01 is ignored like any unknown command, and the STEP states do not exist.

Test Plan:
- Assembly: bytes 01,00,43,20 -> one o_imem_wr_en pulse, addr 0, data 32'h20430001.
- Load end: 3 words, then FC000000, then 00000000 -> 5 writes at addr 0..4; o_state=WAIT_CMD; a further byte 8'h00 starts RUN.
- Run/halt: cmd 00; i_halt asserted 40 cycles later -> o_cpu_enable high exactly 40 cycles, then 0. With i_pc=32'h0000002C, first tx bytes are 2C,00,00,00; 260 o_tx_signal pulses total; each pulse follows the previous i_tx_done.
- Dump data: register 9 returns 32'hDEADBEEF -> bytes EF,BE,AD,DE at tx byte indices 40..43. o_reg_addr sequences 0..31 and o_mem_addr sequences 0..31.
- Robustness:
  - Unknown command 8'h7F in WAIT_CMD -> no state change.
  - i_reset asserted mid-dump (byte 100) -> all outputs 0 the same cycle; a new load starts at addr 0.
- Step (DEBUG_STEP_EN): cmd 01, then 02 -> exactly one enable cycle, then 260 bytes; the FSM is back in STEP.

Source files
------------

// File: rtl/debug_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_unit_if
//  Description : Signal bundle between the debug unit and its surroundings
//                (UART byte streams, instruction-memory write port, CPU run
//                control and debug read ports of register file / data memory).
//  Modports    : slave  - the debug unit itself (drives the o_* signals)
//                master - the UART / pipeline side (drives the i_* signals)
//  Ports       : i_rx_done, i_rx_data        received UART byte + strobe
//                i_tx_done, o_tx_signal,
//                o_tx_result                 transmit handshake and byte
//                o_imem_wr_en/addr/data      instruction memory write
//                o_cpu_enable, i_halt, i_pc  pipeline run control / status
//                o_reg_addr, i_reg_data      register file debug read
//                o_mem_addr, i_mem_data      data memory debug read
//                o_state                     FSM state for debug
//  Revision    : 1.0 - initial release
// ============================================================================
interface debug_unit_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int IMEM_ADDR_WIDTH = 8
);
    logic                       i_rx_done;
    logic [DATA_WIDTH_UART-1:0] i_rx_data;
    logic                       i_tx_done;
    logic                       o_tx_signal;
    logic [DATA_WIDTH_UART-1:0] o_tx_result;
    logic                       o_imem_wr_en;
    logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
    logic [DATA_WIDTH-1:0]      o_imem_data;
    logic                       o_cpu_enable;
    logic                       i_halt;
    logic [DATA_WIDTH-1:0]      i_pc;
    logic [4:0]                 o_reg_addr;
    logic [DATA_WIDTH-1:0]      i_reg_data;
    logic [DATA_WIDTH-1:0]      o_mem_addr;
    logic [DATA_WIDTH-1:0]      i_mem_data;
    logic [2:0]                 o_state;

    modport slave (
        input  i_rx_done, i_rx_data, i_tx_done, i_halt, i_pc, i_reg_data, i_mem_data,
        output o_tx_signal, o_tx_result, o_imem_wr_en, o_imem_addr, o_imem_data,
               o_cpu_enable, o_reg_addr, o_mem_addr, o_state
    );

    modport master (
        output i_rx_done, i_rx_data, i_tx_done, i_halt, i_pc, i_reg_data, i_mem_data,
        input  o_tx_signal, o_tx_result, o_imem_wr_en, o_imem_addr, o_imem_data,
               o_cpu_enable, o_reg_addr, o_mem_addr, o_state
    );
endinterface
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
//  Module      : debug_unit
//  Description : UART-driven loader / run controller / state dumper for the
//                MIPS pipeline. Assembles received bytes (LSB first) into
//                instruction words, writes them to instruction memory until
//                a halt word followed by an all-zero word (or memory full),
//                waits for command 0x00, runs the CPU until it halts, then
//                streams PC, NREGS registers and NMEMWORDS data-memory words
//                back over the UART, 4 bytes each, LSB first.
//  Ports       : i_clock, i_reset (async, active-high), dbg (debug_unit_if
//                slave modport: UART, imem write, CPU control, debug reads)
//  Options     : DEBUG_STEP_EN - adds a single-step mode: command 0x01 enters
//                STEP, each byte 0x02 runs one cycle followed by a full dump.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_unit #(
    parameter int         DATA_WIDTH      = 32,
    parameter int         DATA_WIDTH_UART = 8,
    parameter int         IMEM_ADDR_WIDTH = 8,
    parameter int         NREGS           = 32,
    parameter int         NMEMWORDS       = 32,
    parameter logic [5:0] HALT_OPCODE     = 6'b111111
) (
    input  wire logic   i_clock,
    input  wire logic   i_reset,
    debug_unit_if.slave dbg
);
    localparam int BYTES     = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LAST_ITEM = NREGS + NMEMWORDS;
    localparam int ITEM_W    = $clog2(LAST_ITEM + 1);

    localparam logic [BC_W-1:0]   LAST_BYTE  = BC_W'(BYTES - 1);
    localparam logic [ITEM_W-1:0] ITEM_LAST  = ITEM_W'(LAST_ITEM);
    localparam logic [ITEM_W-1:0] ITEM_NREGS = ITEM_W'(NREGS);
    localparam logic [ITEM_W-1:0] MEM_BASE   = ITEM_W'(NREGS + 1);

    // Encoding is visible on o_state; keep values stable for debug tools.
    typedef enum logic [2:0] {
        S_LOAD       = 3'd0,
        S_LOAD_WR    = 3'd1,
        S_WAIT_CMD   = 3'd2,
        S_RUN        = 3'd3,
        S_DUMP_SETUP = 3'd4,
        S_DUMP_WAIT  = 3'd5,
        S_DUMP_TX    = 3'd6
`ifdef DEBUG_STEP_EN
        ,S_STEP      = 3'd7
`endif
    } state_t;

    state_t                     state_q, state_d;
    logic [BC_W-1:0]            bytecnt_q, bytecnt_d;
    logic [DATA_WIDTH-1:0]      word_q, word_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       halt_seen_q, halt_seen_d;
    logic [ITEM_W-1:0]          item_q, item_d;
    logic [DATA_WIDTH-1:0]      shift_q, shift_d;
    logic                       sent_q, sent_d;
`ifdef DEBUG_STEP_EN
    logic                       step_q, step_d;
`endif

    logic w_tx_signal;
    logic w_imem_wr_en;
    logic w_cpu_enable;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_LOAD;
            bytecnt_q   <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            halt_seen_q <= 1'b0;
            item_q      <= '0;
            shift_q     <= '0;
            sent_q      <= 1'b0;
`ifdef DEBUG_STEP_EN
            step_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bytecnt_q   <= bytecnt_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            halt_seen_q <= halt_seen_d;
            item_q      <= item_d;
            shift_q     <= shift_d;
            sent_q      <= sent_d;
`ifdef DEBUG_STEP_EN
            step_q      <= step_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        bytecnt_d    = bytecnt_q;
        word_d       = word_q;
        addr_d       = addr_q;
        halt_seen_d  = halt_seen_q;
        item_d       = item_q;
        shift_d      = shift_q;
        sent_d       = sent_q;
`ifdef DEBUG_STEP_EN
        step_d       = step_q;
`endif
        w_tx_signal  = 1'b0;
        w_imem_wr_en = 1'b0;
        w_cpu_enable = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (dbg.i_rx_done) begin
                    // New byte enters at the top; after BYTES bytes the first
                    // received byte has reached the LSB position.
                    word_d    = {dbg.i_rx_data, word_q[DATA_WIDTH-1:DATA_WIDTH_UART]};
                    bytecnt_d = bytecnt_q + BC_W'(1);
                    if (bytecnt_q == LAST_BYTE) begin
                        bytecnt_d = '0;
                        state_d   = S_LOAD_WR;
                    end
                end
            end

            S_LOAD_WR: begin
                w_imem_wr_en = 1'b1;
                addr_d       = addr_q + IMEM_ADDR_WIDTH'(1);
                if (word_q[DATA_WIDTH-1 -: 6] == HALT_OPCODE) begin
                    halt_seen_d = 1'b1;
                end
                // A zero word only terminates the load once a halt has been
                // loaded earlier; zero words before that are ordinary NOPs.
                if ((halt_seen_q && (word_q == '0)) || (addr_q == '1)) begin
                    state_d = S_WAIT_CMD;
                end else begin
                    state_d = S_LOAD;
                end
            end

            S_WAIT_CMD: begin
                if (dbg.i_rx_done) begin
                    if (dbg.i_rx_data == DATA_WIDTH_UART'(8'h00)) begin
                        state_d = S_RUN;
`ifdef DEBUG_STEP_EN
                        step_d  = 1'b0;
                    end else if (dbg.i_rx_data == DATA_WIDTH_UART'(8'h01)) begin
                        state_d = S_STEP;
`endif
                    end
                end
            end

`ifdef DEBUG_STEP_EN
            S_STEP: begin
                if (dbg.i_rx_done && (dbg.i_rx_data == DATA_WIDTH_UART'(8'h02))) begin
                    step_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
`endif

            S_RUN: begin
                w_cpu_enable = 1'b1;
`ifdef DEBUG_STEP_EN
                // A step run lasts exactly this one cycle.
                if (step_q || dbg.i_halt) begin
                    state_d = S_DUMP_SETUP;
                end
`else
                if (dbg.i_halt) begin
                    state_d = S_DUMP_SETUP;
                end
`endif
            end

            S_DUMP_SETUP: begin
                // Read addresses are decoded from item_q; give the memories
                // their one cycle of latency before latching.
                state_d = S_DUMP_WAIT;
            end

            S_DUMP_WAIT: begin
                if (item_q == '0) begin
                    shift_d = dbg.i_pc;
                end else if (item_q <= ITEM_NREGS) begin
                    shift_d = dbg.i_reg_data;
                end else begin
                    shift_d = dbg.i_mem_data;
                end
                sent_d  = 1'b0;
                state_d = S_DUMP_TX;
            end

            S_DUMP_TX: begin
                if (!sent_q) begin
                    w_tx_signal = 1'b1;
                    sent_d      = 1'b1;
                end else if (dbg.i_tx_done) begin
                    sent_d    = 1'b0;
                    shift_d   = shift_q >> DATA_WIDTH_UART;
                    bytecnt_d = bytecnt_q + BC_W'(1);
                    if (bytecnt_q == LAST_BYTE) begin
                        bytecnt_d = '0;
                        if (item_q == ITEM_LAST) begin
                            item_d = '0;
`ifdef DEBUG_STEP_EN
                            step_d = 1'b0;
                            if (step_q && !dbg.i_halt) begin
                                state_d = S_STEP;
                            end else begin
                                state_d     = S_LOAD;
                                addr_d      = '0;
                                halt_seen_d = 1'b0;
                            end
`else
                            state_d     = S_LOAD;
                            addr_d      = '0;
                            halt_seen_d = 1'b0;
`endif
                        end else begin
                            item_d  = item_q + ITEM_W'(1);
                            state_d = S_DUMP_SETUP;
                        end
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Outputs are gated so that every output reads 0 whenever the block is
    // idle or held in reset.
    assign dbg.o_tx_signal  = w_tx_signal;
    assign dbg.o_tx_result  = (state_q == S_DUMP_TX) ? shift_q[DATA_WIDTH_UART-1:0] : '0;
    assign dbg.o_imem_wr_en = w_imem_wr_en;
    assign dbg.o_imem_addr  = w_imem_wr_en ? addr_q : '0;
    assign dbg.o_imem_data  = w_imem_wr_en ? word_q : '0;
    assign dbg.o_cpu_enable = w_cpu_enable;
    // Item 0 is the PC, items 1..NREGS map to registers 0..NREGS-1 and the
    // rest to data-memory words 0..NMEMWORDS-1.
    assign dbg.o_reg_addr   = ((item_q != '0) && (item_q <= ITEM_NREGS)) ?
                              5'(item_q - ITEM_W'(1)) : 5'd0;
    assign dbg.o_mem_addr   = (item_q >= MEM_BASE) ?
                              DATA_WIDTH'(item_q - MEM_BASE) : '0;
    assign dbg.o_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_unit
//  Description : Self-checking bench for debug_unit. Loads programs over a
//                modelled UART, runs/halts the CPU, and compares the dumped
//                byte stream and instruction-memory writes against a
//                reference model built from the load/dump rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_unit;
    localparam int NBYTES      = 260;
    localparam int ST_LOAD     = 0;
    localparam int ST_WAIT_CMD = 2;
    localparam int ST_STEP     = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    debug_unit_if bus ();
    debug_unit dut (.i_clock(clk), .i_reset(rst), .dbg(bus));

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32];
    logic [31:0] dmem [32];
    logic [31:0] words [$];
    logic [39:0] expwr [$];
    logic [7:0]  expd  [$];

    // Debug read ports with one cycle of read latency.
    always @(posedge clk) begin
        bus.i_reg_data <= regs[bus.o_reg_addr];
        bus.i_mem_data <= dmem[bus.o_mem_addr[4:0]];
    end

    // Monitor + UART transmitter model: records writes and sent bytes,
    // answers each byte with i_tx_done after a random delay.
    logic [7:0]  txq [$];
    logic [39:0] wrq [$];
    int          en_cnt = 0;
    int          viol   = 0;
    bit          pending = 1'b0;
    int          dly    = 0;
    logic [7:0]  held;

    always @(negedge clk) begin
        if (rst) begin
            pending       = 1'b0;
            bus.i_tx_done = 1'b0;
        end else begin
            bus.i_tx_done = 1'b0;
            if (pending) begin
                if (bus.o_tx_result !== held) viol++;
                if (dly == 0) begin
                    bus.i_tx_done = 1'b1;
                    pending       = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (bus.o_tx_signal) begin
                if (pending) viol++;
                pending = 1'b1;
                held    = bus.o_tx_result;
                dly     = $urandom_range(0, 4);
                txq.push_back(bus.o_tx_result);
            end
            if (bus.o_imem_wr_en) wrq.push_back({bus.o_imem_addr, bus.o_imem_data});
            if (bus.o_cpu_enable) en_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); #1;
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk); #1;
        bus.i_rx_done = 1'b0;
        tick($urandom_range(1, 3));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31:26] = 6'h01;
        if (w == 32'h0) w = 32'h1;
        return w;
    endfunction

    // Expected imem writes for the program in 'words'.
    task automatic model_load();
        int a;
        bit hs;
        a  = 0;
        hs = 1'b0;
        expwr.delete();
        foreach (words[i]) begin
            expwr.push_back({a[7:0], words[i]});
            if (hs && words[i] == 32'h0) break;
            if (words[i][31:26] == 6'h3F) hs = 1'b1;
            if (a == 255) break;
            a++;
        end
    endtask

    // Expected dump: PC, then registers, then data memory, LSB first.
    task automatic model_dump();
        logic [31:0] v;
        expd.delete();
        for (int it = 0; it < 65; it++) begin
            if (it == 0)       v = bus.i_pc;
            else if (it <= 32) v = regs[it-1];
            else               v = dmem[it-33];
            for (int b = 0; b < 4; b++) expd.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic load_and_check(input string tag);
        int w0;
        int m;
        w0 = wrq.size();
        foreach (words[i]) send_word(words[i]);
        tick(3);
        model_load();
        check({tag, "_wr_count"}, wrq.size() - w0, expwr.size());
        m = 0;
        foreach (expwr[i]) if (wrq[w0+i] !== expwr[i]) m++;
        check({tag, "_wr_data"}, m, 0);
        check({tag, "_first_addr"}, wrq[w0][39:32], 8'h00);
        check({tag, "_state"}, bus.o_state, ST_WAIT_CMD);
    endtask

    task automatic wait_tx(input int n);
        int c;
        c = 0;
        while (txq.size() < n && c < 20000) begin
            @(negedge clk); #1;
            c++;
        end
    endtask

    task automatic cmp_dump(input int b0, input string tag);
        int m;
        m = 0;
        for (int i = 0; i < NBYTES; i++) if (txq[b0+i] !== expd[i]) m++;
        check({tag, "_count"}, txq.size() - b0, NBYTES);
        check({tag, "_bytes"}, m, 0);
        check({tag, "_proto"}, viol, 0);
    endtask

    initial begin
        int b0;
        int e0;
        int w0;
        int k;
        int cyc;

        rst           = 1'b1;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_halt    = 1'b0;
        bus.i_pc      = 32'h0000002C;
        foreach (regs[i]) regs[i] = $urandom;
        foreach (dmem[i]) dmem[i] = $urandom;
        regs[9] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {bus.o_tx_signal, bus.o_tx_result, bus.o_imem_wr_en, bus.o_imem_addr,
                             bus.o_cpu_enable, bus.o_reg_addr, bus.o_state}, 0);
        check("reset_data", {bus.o_imem_data, bus.o_mem_addr}, 0);
        rst = 1'b0;
        tick(2);
        check("reset_state", bus.o_state, ST_LOAD);

        // Single word assembly.
        w0 = wrq.size();
        send_word(32'h20430001);
        tick(2);
        check("asm_count", wrq.size() - w0, 1);
        check("asm_write", wrq[w0], {8'h00, 32'h20430001});

        // Rest of the program: two words, halt, end marker.
        words.delete();
        words.push_back(rand_word());
        words.push_back(rand_word());
        words.push_back(32'hFC000000);
        words.push_back(32'h00000000);
        w0 = wrq.size();
        foreach (words[i]) send_word(words[i]);
        tick(3);
        words.push_front(32'h20430001);
        model_load();
        check("load1_wr_count", wrq.size() - w0 + 1, expwr.size());
        k = 0;
        foreach (expwr[i]) if (wrq[w0-1+i] !== expwr[i]) k++;
        check("load1_wr_data", k, 0);
        check("load1_state", bus.o_state, ST_WAIT_CMD);

        // Unknown command is ignored.
        send_byte(8'h7F);
        tick(3);
        check("unknown_cmd_state", bus.o_state, ST_WAIT_CMD);
        check("unknown_cmd_en", bus.o_cpu_enable, 1'b0);

        // Run for 40 cycles, then halt and dump.
        e0 = en_cnt;
        b0 = txq.size();
        @(negedge clk); #1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b1;
        @(negedge clk); #1;
        bus.i_rx_done = 1'b0;
        k   = 0;
        cyc = 0;
        while (cyc < 1000) begin
            if (bus.o_cpu_enable) k++;
            if (k == 40) break;
            @(negedge clk); #1;
            cyc++;
        end
        bus.i_halt = 1'b1;
        tick(3);
        check("run_en_cycles", en_cnt - e0, 40);
        check("run_en_off", bus.o_cpu_enable, 1'b0);
        model_dump();
        wait_tx(b0 + NBYTES);
        tick(20);
        cmp_dump(b0, "dump1");
        check("dump1_pc", {txq[b0+3], txq[b0+2], txq[b0+1], txq[b0]}, 32'h0000002C);
        check("dump1_r9", {txq[b0+43], txq[b0+42], txq[b0+41], txq[b0+40]}, 32'hDEADBEEF);
        check("dump1_end_state", bus.o_state, ST_LOAD);
        bus.i_halt = 1'b0;

        // Second program: a zero word before the halt is a plain word.
        words.delete();
        words.push_back(rand_word());
        words.push_back(32'h00000000);
        words.push_back(32'hFC000000 | ($urandom & 32'h03FFFFFF));
        words.push_back(32'h00000000);
        load_and_check("load2");

        // Halt already high on entry: one enable cycle, then dump; reset mid-dump.
        foreach (regs[i]) regs[i] = $urandom;
        bus.i_halt = 1'b1;
        e0 = en_cnt;
        b0 = txq.size();
        send_byte(8'h00);
        tick(2);
        check("halt_entry_en", en_cnt - e0, 1);
        wait_tx(b0 + 100);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midreset_ctrl", {bus.o_tx_signal, bus.o_tx_result, bus.o_imem_wr_en, bus.o_imem_addr,
                                bus.o_cpu_enable, bus.o_reg_addr, bus.o_state}, 0);
        check("midreset_data", {bus.o_imem_data, bus.o_mem_addr}, 0);
        @(negedge clk); #1;
        rst        = 1'b0;
        bus.i_halt = 1'b0;
        tick(2);

        words.delete();
        words.push_back(rand_word());
        words.push_back(32'hFC000000);
        words.push_back(32'h00000000);
        load_and_check("load3");

`ifdef DEBUG_STEP_EN
        send_byte(8'h01);
        tick(2);
        check("step_enter", bus.o_state, ST_STEP);
        foreach (dmem[i]) dmem[i] = $urandom;
        bus.i_pc = $urandom;
        e0 = en_cnt;
        b0 = txq.size();
        model_dump();
        send_byte(8'h02);
        wait_tx(b0 + NBYTES);
        tick(20);
        check("step_en_cycles", en_cnt - e0, 1);
        cmp_dump(b0, "step_dump");
        check("step_return", bus.o_state, ST_STEP);
`else
        e0 = en_cnt;
        b0 = txq.size();
        send_byte(8'h01);
        tick(3);
        check("cmd01_ignored", bus.o_state, ST_WAIT_CMD);
        check("cmd01_no_en", en_cnt - e0, 0);
        check("cmd01_no_tx", txq.size() - b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
